// File: rtl/wired_cdb_arbiter_pkg.sv
// Shared CDB types, source index constants and small helpers used by the
// CDB arbiter and its per-source skid FIFOs.
package wired_cdb_arbiter_pkg;

  localparam int WID_W   = 6;
  localparam int DATA_W  = 16;
  localparam int N_LANES = 2;

  localparam int CDB_SRC_ALU0 = 0;
  localparam int CDB_SRC_ALU1 = 1;
  localparam int CDB_SRC_LSU  = 2;
  localparam int CDB_SRC_MDU  = 3;

  // Result as handed over by an issue queue; wid is the ROB index, wid[0] its bank.
  typedef struct packed {
    logic [WID_W-1:0]  wid;
    logic [DATA_W-1:0] data;
    logic              exc;
  } pipeline_cdb_t;

  // Result as broadcast on one CDB lane.
  typedef struct packed {
    logic [WID_W-1:0]  wid;
    logic [DATA_W-1:0] data;
    logic              exc;
  } pipeline_cdb_data_t;

  localparam int CDB_W      = $bits(pipeline_cdb_t);
  localparam int CDB_DATA_W = $bits(pipeline_cdb_data_t);

  function automatic pipeline_cdb_data_t to_cdb_data(input pipeline_cdb_t p);
    pipeline_cdb_data_t r;
    r.wid  = p.wid;
    r.data = p.data;
    r.exc  = p.exc;
    return r;
  endfunction

  function automatic logic cdb_bank(input pipeline_cdb_t p);
    return p.wid[0];
  endfunction

endpackage

// File: rtl/wired_cdb_arbiter_skid.sv
// Small per-source skid FIFO: power-of-two depth, combinational head,
// simultaneous push/pop allowed, flush empties it in one cycle.
module wired_cdb_arbiter_skid #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/wired_cdb_arbiter.sv
// Collects finished results from the IQs and broadcasts them on two bank-split
// CDB lanes, fixed priority by source index (0 highest).
module wired_cdb_arbiter
  import wired_cdb_arbiter_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int SKID_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC*CDB_W-1:0]        src_payload_i,
  input  logic [N_SRC-1:0]              src_valid_i,
  output logic [N_SRC-1:0]              src_ready_o,
  output logic [N_LANES*CDB_DATA_W-1:0] cdb_o,
  output logic [N_LANES-1:0]            cdb_valid_o,
  input  logic                          flush_i
);

  logic [CDB_W-1:0]   head_raw [N_SRC];
  pipeline_cdb_t      head     [N_SRC];
  logic [N_SRC-1:0]   full;
  logic [N_SRC-1:0]   empty;
  logic [N_SRC-1:0]   push;
  logic [N_SRC-1:0]   pop;
  logic [N_SRC-1:0]   grant [N_LANES];

  pipeline_cdb_data_t cdb_q [N_LANES];
  pipeline_cdb_data_t cdb_d [N_LANES];
  logic [N_LANES-1:0] cdb_valid_q, cdb_valid_d;

  // Ready is purely occupancy based so it never loops back from src_valid_i.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign push[gi] = src_valid_i[gi] & ~full[gi] & ~flush_i;

      wired_cdb_arbiter_skid #(
        .DEPTH (SKID_DEPTH),
        .W     (CDB_W)
      ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .push_i  (push[gi]),
        .din_i   (src_payload_i[gi*CDB_W +: CDB_W]),
        .pop_i   (pop[gi]),
        .head_o  (head_raw[gi]),
        .full_o  (full[gi]),
        .empty_o (empty[gi])
      );

      assign head[gi]        = head_raw[gi];
      assign src_ready_o[gi] = ~full[gi];
    end
  endgenerate

  // Per bank: first nonempty source (lowest index) whose head targets that bank.
  always_comb begin
    for (int b = 0; b < N_LANES; b++) begin
      grant[b] = '0;
      for (int s = 0; s < N_SRC; s++) begin
        if (grant[b] == '0 && !empty[s] && cdb_bank(head[s]) == 1'(b)) begin
          grant[b][s] = 1'b1;
        end
      end
    end
  end

  // A head belongs to exactly one bank, so a source is popped at most once.
  always_comb begin
    pop = '0;
    for (int b = 0; b < N_LANES; b++) begin
      pop = pop | grant[b];
    end
    if (flush_i) begin
      pop = '0;
    end
  end

  always_comb begin
    for (int b = 0; b < N_LANES; b++) begin
      cdb_d[b]       = cdb_q[b];
      cdb_valid_d[b] = 1'b0;
      if (!flush_i && grant[b] != '0) begin
        cdb_valid_d[b] = 1'b1;
        for (int s = 0; s < N_SRC; s++) begin
          if (grant[b][s]) begin
            cdb_d[b] = to_cdb_data(head[s]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= '0;
      for (int b = 0; b < N_LANES; b++) begin
        cdb_q[b] <= '0;
      end
    end else begin
      cdb_valid_q <= cdb_valid_d;
      for (int b = 0; b < N_LANES; b++) begin
        cdb_q[b] <= cdb_d[b];
      end
    end
  end

  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      assign cdb_o[gi*CDB_DATA_W +: CDB_DATA_W] = cdb_q[gi];
    end
  endgenerate

  assign cdb_valid_o = cdb_valid_q;

endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Bench for wired_cdb_arbiter: queue-based reference model checked every cycle
// on two instances (skid depth 2 and 4), plus directed scenarios with literal expectations.
module tb_wired_cdb_arbiter;
  import wired_cdb_arbiter_pkg::*;

  localparam int NS = 4;
  localparam int NK = 2;

  typedef logic [CDB_W-1:0] pay_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [NS*CDB_W-1:0]        pay  [NK];
  logic [NS-1:0]              vld  [NK];
  logic [NS-1:0]              rdy  [NK];
  logic [2*CDB_DATA_W-1:0]    cdb  [NK];
  logic [1:0]                 cvld [NK];

  always #5 clk = ~clk;

  wired_cdb_arbiter #(.N_SRC(NS), .SKID_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .src_payload_i(pay[0]), .src_valid_i(vld[0]),
    .src_ready_o(rdy[0]), .cdb_o(cdb[0]), .cdb_valid_o(cvld[0]), .flush_i(flush)
  );

  wired_cdb_arbiter #(.N_SRC(NS), .SKID_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .src_payload_i(pay[1]), .src_valid_i(vld[1]),
    .src_ready_o(rdy[1]), .cdb_o(cdb[1]), .cdb_valid_o(cvld[1]), .flush_i(flush)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bank_of(input pay_t p);
    pipeline_cdb_t t;
    t = p;
    return t.wid[0];
  endfunction

  function automatic logic [WID_W-1:0] lane_wid(input int k, input int b);
    pipeline_cdb_data_t t;
    t = cdb[k][b*CDB_DATA_W +: CDB_DATA_W];
    return t.wid;
  endfunction

  // ---------------- reference model: one FIFO queue per source ----------------
  pay_t       mq [NK*NS][$];
  logic [1:0] exp_v   [NK];
  pay_t       exp_cdb [NK][2];
  int         model_push [NK];
  int         dut_bcast  [NK];
  bit         model_live = 0;

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NK; k++) begin
      if (rst || flush) begin
        for (int s = 0; s < NS; s++) mq[k*NS+s].delete();
        exp_v[k] = 2'b00;
        if (rst) begin
          exp_cdb[k][0] = '0;
          exp_cdb[k][1] = '0;
        end
      end else begin
        bit room [NS];
        bit taken [NS];
        for (int s = 0; s < NS; s++) begin
          room[s]  = mq[k*NS+s].size() < depth_of(k);
          taken[s] = 0;
        end
        exp_v[k] = 2'b00;
        for (int b = 0; b < 2; b++) begin
          for (int s = 0; s < NS; s++) begin
            if (!exp_v[k][b] && mq[k*NS+s].size() > 0 && bank_of(mq[k*NS+s][0]) == b[0]) begin
              exp_v[k][b]   = 1'b1;
              exp_cdb[k][b] = mq[k*NS+s][0];
              taken[s]      = 1;
            end
          end
        end
        for (int s = 0; s < NS; s++) begin
          if (taken[s]) void'(mq[k*NS+s].pop_front());
          if (vld[k][s] && room[s]) begin
            mq[k*NS+s].push_back(pay[k][s*CDB_W +: CDB_W]);
            model_push[k]++;
          end
        end
      end
    end
    if (rst) model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      for (int k = 0; k < NK; k++) begin
        logic [NS-1:0] er;
        for (int s = 0; s < NS; s++) er[s] = mq[k*NS+s].size() < depth_of(k);
        check($sformatf("model_ready[%0d]", k), 64'(rdy[k]), 64'(er));
        check($sformatf("model_cdb_valid[%0d]", k), 64'(cvld[k]), 64'(exp_v[k]));
        for (int b = 0; b < 2; b++) begin
          check($sformatf("model_cdb[%0d][%0d]", k, b),
                64'(cdb[k][b*CDB_DATA_W +: CDB_DATA_W]), 64'(exp_cdb[k][b]));
          if (cvld[k][b] === 1'b1) begin
            check($sformatf("lane_bank[%0d][%0d]", k, b), 64'(lane_wid(k, b) & 1), 64'(b));
            dut_bcast[k]++;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input int k, input int s, input int wid, input int data);
    pipeline_cdb_t p;
    p.wid  = WID_W'(wid);
    p.data = DATA_W'(data);
    p.exc  = 1'b0;
    pay[k][s*CDB_W +: CDB_W] = p;
    vld[k][s] = 1'b1;
  endtask

  task automatic idle(input int k);
    vld[k] = '0;
  endtask

  initial begin
    bit rdy_seen [NK][NS];
    rst   = 1'b1;
    flush = 1'b0;
    pay[0] = '0;
    pay[1] = '0;
    vld[0] = 4'hF;
    vld[1] = 4'h0;
    for (int k = 0; k < NK; k++) begin
      model_push[k] = 0;
      dut_bcast[k]  = 0;
    end

    // Reset held two cycles with all sources valid.
    step();
    check("reset_valid_c1", 64'(cvld[0]), 64'h0);
    step();
    check("reset_valid_c2", 64'(cvld[0]), 64'h0);
    check("reset_cdb_zero", 64'(cdb[0]), 64'h0);
    rst = 1'b0;
    idle(0);
    step();
    check("reset_ready_after", 64'(rdy[0]), 64'hF);
    check("reset_no_bcast", 64'(cvld[0]), 64'h0);
    $display("reset test done");

    // Bank split: ALU0 wid 6 (bank0), LSU wid 9 (bank1).
    drive(0, CDB_SRC_ALU0, 6, 16'h1111);
    drive(0, CDB_SRC_LSU,  9, 16'h2222);
    step();
    idle(0);
    step();
    check("split_valid", 64'(cvld[0]), 64'h3);
    check("split_lane0_wid", 64'(lane_wid(0, 0)), 64'd6);
    check("split_lane1_wid", 64'(lane_wid(0, 1)), 64'd9);
    $display("bank split test done");

    // Conflict: ALU1 wid 4 and MDU wid 8, both bank0.
    drive(0, CDB_SRC_ALU1, 4, 16'h3333);
    drive(0, CDB_SRC_MDU,  8, 16'h4444);
    step();
    idle(0);
    step();
    check("conflict_c1_valid", 64'(cvld[0]), 64'h1);
    check("conflict_c1_wid", 64'(lane_wid(0, 0)), 64'd4);
    check("conflict_mdu_ready", 64'(rdy[0][CDB_SRC_MDU]), 64'h1);
    step();
    check("conflict_c2_valid", 64'(cvld[0]), 64'h1);
    check("conflict_c2_wid", 64'(lane_wid(0, 0)), 64'd8);
    $display("conflict test done");
    repeat (2) step();

    // Backpressure: ALU0 bank0 for 6 cycles, LSU bank0 x3 held until taken.
    for (int c = 0; c <= 10; c++) begin
      idle(0);
      if (c <= 5) drive(0, CDB_SRC_ALU0, 10 + 2*c, c);
      if (c == 0) drive(0, CDB_SRC_LSU, 20, 16'h00A0);
      if (c == 1) drive(0, CDB_SRC_LSU, 22, 16'h00A1);
      if (c >= 2 && c <= 8) drive(0, CDB_SRC_LSU, 24, 16'h00A2);
      if (c == 2) check("bp_lsu_ready_low", 64'(rdy[0][CDB_SRC_LSU]), 64'h0);
      if (c == 8) begin
        check("bp_lsu_first", 64'(lane_wid(0, 0)), 64'd20);
        check("bp_lsu_ready_back", 64'(rdy[0][CDB_SRC_LSU]), 64'h1);
      end
      if (c == 9)  check("bp_lsu_second", 64'(lane_wid(0, 0)), 64'd22);
      if (c == 10) check("bp_lsu_third", 64'(lane_wid(0, 0)), 64'd24);
      step();
    end
    idle(0);
    repeat (2) step();
    $display("backpressure test done");

    // Flush with ALU0 and MDU holding results (bank1).
    drive(0, CDB_SRC_ALU0, 1, 16'h0B01);
    drive(0, CDB_SRC_MDU,  3, 16'h0B03);
    step();
    drive(0, CDB_SRC_ALU0, 5, 16'h0B05);
    drive(0, CDB_SRC_MDU,  7, 16'h0B07);
    step();
    idle(0);
    drive(0, CDB_SRC_ALU0, 9, 16'h0B09);
    check("flush_mdu_full", 64'(rdy[0][CDB_SRC_MDU]), 64'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(0);
    check("flush_valid_next", 64'(cvld[0]), 64'h0);
    check("flush_ready_all", 64'(rdy[0]), 64'hF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_stale", 64'(cvld[0]), 64'h0);
    end
    $display("flush test done");

    // Random traffic on both instances; IQ-style hold of payload while not ready.
    for (int k = 0; k < NK; k++) begin
      model_push[k] = 0;
      dut_bcast[k]  = 0;
      for (int s = 0; s < NS; s++) rdy_seen[k][s] = 0;
    end
    repeat (1200) begin
      for (int k = 0; k < NK; k++) begin
        for (int s = 0; s < NS; s++) begin
          if (vld[k][s] && rdy_seen[k][s]) vld[k][s] = 1'b0;
          if (!vld[k][s] && ($urandom % 4) != 0)
            drive(k, s, int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)));
          rdy_seen[k][s] = rdy[k][s];
        end
      end
      step();
    end
    for (int k = 0; k < NK; k++) begin
      for (int s = 0; s < NS; s++) begin
        if (vld[k][s] && rdy_seen[k][s]) vld[k][s] = 1'b0;
      end
    end
    step();
    idle(0);
    idle(1);
    repeat (20) step();
    for (int k = 0; k < NK; k++) begin
      check($sformatf("random_bcast_count[%0d]", k), 64'(dut_bcast[k]), 64'(model_push[k]));
      $display("random depth %0d: %0d results pushed", depth_of(k), model_push[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
